// File: rtl/minibyte_load_pkg.sv
// MiniByte boot/run controller shared types.
// State encoding, parameter bounds and output decode.
package minibyte_load_pkg;

    typedef enum logic [2:0] {
        HALT     = 3'd0,
        LD_WAIT  = 3'd1,
        LD_SETUP = 3'd2,
        LD_WRITE = 3'd3,
        LD_HOLD  = 3'd4,
        RUN      = 3'd5
    } state_t;

    localparam int WE_CYCLES_MIN = 1;
    localparam int WE_CYCLES_MAX = 4;

    localparam logic [8:0] LEN_ZERO_MEANS_256 = 9'd256;

    typedef struct packed {
        logic ready;
        logic busy;
        logic we;
        logic drive;
        logic cpu_rst;
        logic cpu_own;
    } ctl_t;

    // Registered control bits for the state being entered
    function automatic ctl_t decode(state_t s);
        ctl_t c;
        c = '0;
        c.cpu_rst = 1'b1;
        unique case (s)
            HALT: ;
            LD_WAIT: begin
                c.ready = 1'b1;
                c.busy  = 1'b1;
                c.drive = 1'b1;
            end
            LD_SETUP, LD_HOLD: begin
                c.busy  = 1'b1;
                c.drive = 1'b1;
            end
            LD_WRITE: begin
                c.busy  = 1'b1;
                c.drive = 1'b1;
                c.we    = 1'b1;
            end
            RUN: begin
                c.cpu_rst = 1'b0;
                c.cpu_own = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/minibyte_load_ctrl_if.sv
// Host, CPU and external-memory signals of the controller.
// slave = controller side, master = environment side.
interface minibyte_load_ctrl_if;

    logic       load_start_in;
    logic [7:0] load_base_in;
    logic [7:0] load_len_in;
    logic       run_in;
    logic       host_valid_in;
    logic [7:0] host_data_in;
    logic       host_ready_out;
    logic [7:0] cpu_addr_in;
    logic [7:0] cpu_data_in;
    logic       cpu_we_in;
    logic       cpu_drive_in;
    logic [7:0] mem_addr_out;
    logic [7:0] mem_data_out;
    logic       mem_we_out;
    logic       mem_drive_out;
    logic       cpu_rst_out;
    logic       busy_out;
    logic       done_out;
    logic [7:0] count_out;

    modport slave (
        input  load_start_in, load_base_in, load_len_in, run_in,
        input  host_valid_in, host_data_in,
        input  cpu_addr_in, cpu_data_in, cpu_we_in, cpu_drive_in,
        output host_ready_out,
        output mem_addr_out, mem_data_out, mem_we_out, mem_drive_out,
        output cpu_rst_out, busy_out, done_out, count_out
    );

    modport master (
        output load_start_in, load_base_in, load_len_in, run_in,
        output host_valid_in, host_data_in,
        output cpu_addr_in, cpu_data_in, cpu_we_in, cpu_drive_in,
        input  host_ready_out,
        input  mem_addr_out, mem_data_out, mem_we_out, mem_drive_out,
        input  cpu_rst_out, busy_out, done_out, count_out
    );

endinterface

// File: rtl/minibyte_load_busmux.sv
// External memory port select between loader and CPU.
// Select is a registered owner bit, so the switch is glitch-free.
module minibyte_load_busmux (
    input  logic       i_sel_cpu,
    input  logic [7:0] i_ld_addr,
    input  logic [7:0] i_ld_data,
    input  logic       i_ld_we,
    input  logic       i_ld_drive,
    input  logic [7:0] i_cpu_addr,
    input  logic [7:0] i_cpu_data,
    input  logic       i_cpu_we,
    input  logic       i_cpu_drive,
    output logic [7:0] o_addr,
    output logic [7:0] o_data,
    output logic       o_we,
    output logic       o_drive
);

    assign o_addr  = i_sel_cpu ? i_cpu_addr  : i_ld_addr;
    assign o_data  = i_sel_cpu ? i_cpu_data  : i_ld_data;
    assign o_we    = i_sel_cpu ? i_cpu_we    : i_ld_we;
    assign o_drive = i_sel_cpu ? i_cpu_drive : i_ld_drive;

endmodule

// File: rtl/minibyte_load_ctrl.sv
// MiniByte boot/run controller: host byte loader while halted,
// zero-latency CPU passthrough of the memory port while running.
module minibyte_load_ctrl
    import minibyte_load_pkg::*;
#(
    parameter int WE_CYCLES = 1
) (
    input logic                 clk_in,
    input logic                 rst_in,
    minibyte_load_ctrl_if.slave bus
);

    localparam logic [1:0] WE_LAST = 2'(WE_CYCLES - 1);

    state_t     r_state;
    ctl_t       r_ctl;
    logic [7:0] r_ptr;
    logic [8:0] r_rem;
    logic [1:0] r_wcnt;
    logic [7:0] r_data;
    logic [7:0] r_count;
    logic       r_done;
    logic [7:0] w_ld_data;

    // Data pins read 0 whenever the loader is not driving them
    assign w_ld_data = r_ctl.drive ? r_data : 8'h00;

    assign bus.host_ready_out = r_ctl.ready;
    assign bus.busy_out       = r_ctl.busy;
    assign bus.cpu_rst_out    = r_ctl.cpu_rst;
    assign bus.done_out       = r_done;
    assign bus.count_out      = r_count;

    // Load/run sequencer; outputs registered from the state entered
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= HALT;
            r_ctl   <= decode(HALT);
            r_ptr   <= 8'h00;
            r_rem   <= 9'd0;
            r_wcnt  <= 2'd0;
            r_data  <= 8'h00;
            r_count <= 8'h00;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                HALT: begin
                    if (bus.load_start_in) begin
                        r_state <= LD_WAIT;
                        r_ctl   <= decode(LD_WAIT);
                        r_ptr   <= bus.load_base_in;
                        r_rem   <= (bus.load_len_in == 8'd0)
                                   ? LEN_ZERO_MEANS_256
                                   : {1'b0, bus.load_len_in};
                        r_count <= 8'h00;
                    end else if (bus.run_in) begin
                        r_state <= RUN;
                        r_ctl   <= decode(RUN);
                    end
                end
                LD_WAIT: begin
                    if (bus.host_valid_in && r_ctl.ready) begin
                        r_data  <= bus.host_data_in;
                        r_state <= LD_SETUP;
                        r_ctl   <= decode(LD_SETUP);
                    end
                end
                LD_SETUP: begin
                    r_wcnt  <= 2'd0;
                    r_state <= LD_WRITE;
                    r_ctl   <= decode(LD_WRITE);
                end
                LD_WRITE: begin
                    if (r_wcnt == WE_LAST) begin
                        r_state <= LD_HOLD;
                        r_ctl   <= decode(LD_HOLD);
                    end else begin
                        r_wcnt <= r_wcnt + 2'd1;
                    end
                end
                LD_HOLD: begin
                    r_ptr   <= r_ptr + 8'd1;
                    r_count <= r_count + 8'd1;
                    r_rem   <= r_rem - 9'd1;
                    if (r_rem == 9'd1) begin
                        r_state <= HALT;
                        r_ctl   <= decode(HALT);
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= LD_WAIT;
                        r_ctl   <= decode(LD_WAIT);
                    end
                end
                RUN: begin
                    if (!bus.run_in) begin
                        r_state <= HALT;
                        r_ctl   <= decode(HALT);
                    end
                end
                default: begin
                    r_state <= HALT;
                    r_ctl   <= decode(HALT);
                end
            endcase
        end
    end

    minibyte_load_busmux u_mux (
        .i_sel_cpu   (r_ctl.cpu_own),
        .i_ld_addr   (r_ptr),
        .i_ld_data   (w_ld_data),
        .i_ld_we     (r_ctl.we),
        .i_ld_drive  (r_ctl.drive),
        .i_cpu_addr  (bus.cpu_addr_in),
        .i_cpu_data  (bus.cpu_data_in),
        .i_cpu_we    (bus.cpu_we_in),
        .i_cpu_drive (bus.cpu_drive_in),
        .o_addr      (bus.mem_addr_out),
        .o_data      (bus.mem_data_out),
        .o_we        (bus.mem_we_out),
        .o_drive     (bus.mem_drive_out)
    );

endmodule

// File: doc/minibyte_load_ctrl.md
# minibyte_load_ctrl

Boot/run controller for the MiniByte CPU. It owns the single external 8-bit memory port and shares it between two requesters: a host byte-stream loader and the CPU core. While halted, the block holds the CPU in reset and writes host-supplied bytes into external memory at sequential addresses. On a run request it releases the CPU and hands the port over to it as a zero-latency passthrough.

## Interface
Parameters:
- WE_CYCLES, default 1: number of cycles mem_we_out stays high per loaded byte; legal range 1..4.

Ports:
- clk_in  in  1  system clock; all state changes on the rising edge
- rst_in  in  1  reset, asynchronous, active-low
- load_start_in  in  1  one-cycle pulse that starts a load; honoured only in HALT
- load_base_in  in  8  first load address; sampled on load_start_in
- load_len_in  in  8  byte count; sampled on load_start_in; 0 means 256
- run_in  in  1  level; 1 requests CPU execution
- host_valid_in  in  1  host byte valid
- host_data_in  in  8  host byte
- host_ready_out  out  1  controller can accept a byte
- cpu_addr_in / cpu_data_in  in  8 each  CPU address and write-data outputs
- cpu_we_in / cpu_drive_in  in  1 each  CPU write enable and data-drive outputs
- mem_addr_out / mem_data_out  out  8 each  external port address and data
- mem_we_out / mem_drive_out  out  1 each  external write enable and data-pin drive enable
- cpu_rst_out  out  1  CPU core reset, active-high; 1 means the CPU is held
- busy_out  out  1  a load is in progress
- done_out  out  1  one-cycle pulse when a load completes
- count_out  out  8  bytes written so far in the current or last load

## Operation
- State machine states: HALT, LD_WAIT, LD_SETUP, LD_WRITE, LD_HOLD, RUN.
- Values under reset (rst_in low):
  - state is HALT; cpu_rst_out is 1.
  - mem_addr_out, mem_data_out, mem_we_out, mem_drive_out, host_ready_out, busy_out, done_out and count_out are all 0.
  - The internal pointer and remaining-byte counter are 0.
- HALT:
  - load_start_in → LD_WAIT. ptr is loaded from load_base_in; rem is loaded from load_len_in, with 0 mapping to 256 (9-bit); count_out is cleared.
  - Otherwise, run_in → RUN.
  - If load_start_in and run_in are high in the same cycle, the load wins.
- LD_WAIT: host_ready_out is 1. When host_valid_in and host_ready_out are both 1, the byte is latched into a data register and the state goes to LD_SETUP.
- LD_SETUP lasts 1 cycle, then LD_WRITE for WE_CYCLES cycles, then LD_HOLD for 1 cycle.
- Leaving LD_HOLD: ptr increments modulo 256, count_out increments, and rem decrements.
  - If rem becomes 0: go to HALT and pulse done_out in the first HALT cycle.
  - Otherwise: go back to LD_WAIT.
- Bus ownership in the load states (LD_*):
  - mem_addr_out = ptr; mem_data_out = latched byte; mem_drive_out = 1.
  - mem_we_out = 1 only in LD_WRITE.
  - busy_out = 1.
- Bus ownership in HALT: mem_addr_out = ptr, mem_data_out = 0, mem_we_out = 0, mem_drive_out = 0.
- RUN:
  - cpu_rst_out = 0.
  - All mem_* outputs are combinational passthrough of the cpu_* inputs.
  - run_in low → HALT. cpu_rst_out returns to 1 and the bus returns to the HALT values on that same edge.
- cpu_rst_out is a registered decode of the state: 0 only in RUN.
- run_in is ignored while busy; a load cannot be aborted except by rst_in.
- load_start_in is ignored outside HALT.
- host_valid_in is ignored outside LD_WAIT; there is no overflow and no data loss.
- Address wrap: a load with load_base_in = 0xFE and load_len_in = 3 writes addresses 0xFE, 0xFF, 0x00.
- Reset mid-load: the write is abandoned immediately and mem_we_out drops asynchronously. Bytes already written stay in memory.

## Timing
- Load throughput: host_ready_out is low for 2+WE_CYCLES cycles after each accepted byte, so one byte every 3+WE_CYCLES cycles at full host rate.
- Address and data are stable 1 cycle before mem_we_out rises and 1 cycle after it falls.
- Latency from a host handshake edge to mem_we_out high: 1 cycle.
- The RUN passthrough adds zero latency. The mux select comes from a registered state bit, so it produces no glitch on the switch edge.
- From run_in rising in HALT, cpu_rst_out falls after the next clock edge.

## Structure
- Package minibyte_load_pkg holds:
  - the state enumeration, as an explicit 3-bit encoding (HALT = 0 so that reset decodes trivially);
  - the WE_CYCLES bounds;
  - the LEN_ZERO_MEANS_256 constant.
- Sub-module minibyte_load_busmux: a purely combinational 2-to-1 select of {addr, data, we, drive} between the loader and the CPU, driven by a single owner bit.
- The FSM, ptr, rem, the WE_CYCLES counter and the data latch live in the top module.

## Test plan
- Reset then idle: cpu_rst_out = 1, all mem_* = 0, host_ready_out = 0. Assert rst_in low mid-LD_WRITE → mem_we_out drops at once and state returns to HALT.
- Load with base 0x10, len 3, bytes 0xA1, 0xB2, 0xC3 at full rate → writes at 0x10, 0x11, 0x12, each we pulse WE_CYCLES long; done_out pulses once; count_out = 3; ready gaps of 2+WE_CYCLES cycles.
- Wrap and length 0: base 0xFE, len 0 → 256 writes, addresses 0xFE, 0xFF, 0x00 … 0xFD; done_out after the 256th write; count_out wraps to 0.
- Run handover: after a load, raise run_in → cpu_rst_out = 0 next cycle and mem_* track cpu_* combinationally (cpu_addr_in 0x42 → mem_addr_out 0x42). Drop run_in → cpu_rst_out = 1 and mem_we_out = 0 on the same edge.
- Illegal requests: run_in high during a load is ignored until done_out, then RUN is entered; load_start_in in RUN is ignored; load_start_in together with run_in in HALT enters LD_WAIT.
- Host backpressure: host_valid_in held high outside LD_WAIT → no byte is accepted; a valid stalled for 10 cycles in LD_WAIT → the byte is written exactly once.
